// File: rtl/rv32i_trace_pkg.sv
// Shared types for the retirement-trace path: record layout, field widths and field helpers.
// RV32I_TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp to every record.
package rv32i_trace_pkg;

  localparam int unsigned TRACE_SEQ_W = 16;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned TSTAMP_W    = 32;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic                   lost;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        instr;
    logic [REG_AW-1:0]      rd;
    logic [XLEN-1:0]        rd_data;
`ifdef RV32I_TRACE_TIMESTAMP_EN
    logic [TSTAMP_W-1:0]    tstamp;
`endif
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

  // Only report a destination when the instruction really writes one.
  function automatic logic [REG_AW-1:0] trace_rd(input logic regwrite,
                                                 input logic [REG_AW-1:0] rd_addr);
    return regwrite ? rd_addr : '0;
  endfunction

  // x0 writes are architecturally invisible, so their data is zeroed too.
  function automatic logic [XLEN-1:0] trace_rd_data(input logic regwrite,
                                                    input logic [REG_AW-1:0] rd_addr,
                                                    input logic [XLEN-1:0] rd_data);
    return (regwrite && (rd_addr != '0)) ? rd_data : '0;
  endfunction

endpackage

// File: rtl/rv32i_trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module rv32i_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status is decoded purely from registered pointers.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv32i_trace_tx.sv
// Retirement-trace transmitter: captures MEM/WB retirements into records, buffers them,
// and streams them out over valid/ready. RV32I_TRACE_TIMESTAMP_EN adds a cycle timestamp.
module rv32i_trace_tx
  import rv32i_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SEQ_W  = TRACE_SEQ_W,
  parameter int unsigned DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trace_en_i,
  input  logic                     wb_valid_i,
  input  logic [XLEN-1:0]          wb_pc_i,
  input  logic [XLEN-1:0]          wb_instr_i,
  input  logic                     memwb_regwrite,
  input  logic [REG_AW-1:0]        memwb_rd_addr,
  input  logic [XLEN-1:0]          memwb_rd_data,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output trace_rec_t               trace_rec_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  logic [SEQ_W-1:0]       seq_q;
  logic                   lost_q;
  logic [DROP_W-1:0]      drop_q;
  logic                   capture;
  logic                   pop;
  logic                   push_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TRACE_REC_W-1:0] head;
  trace_rec_t             rec;

  assign capture = trace_en_i & wb_valid_i;
  assign pop     = trace_valid_o & trace_ready_i;
  // Same acceptance rule as the FIFO: a simultaneous pop frees the slot.
  assign push_ok = capture & (~fifo_full | pop);

`ifdef RV32I_TRACE_TIMESTAMP_EN
  logic [TSTAMP_W-1:0] cycle_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cycle_q <= '0;
    else        cycle_q <= cycle_q + 1'b1;
  end
`endif

  // Record assembly from the MEM/WB retirement signals.
  always_comb begin
    rec         = '0;
    rec.seq     = TRACE_SEQ_W'(seq_q);
    rec.lost    = lost_q;
    rec.pc      = wb_pc_i;
    rec.instr   = wb_instr_i;
    rec.rd      = trace_rd(memwb_regwrite, memwb_rd_addr);
    rec.rd_data = trace_rd_data(memwb_regwrite, memwb_rd_addr, memwb_rd_data);
`ifdef RV32I_TRACE_TIMESTAMP_EN
    rec.tstamp  = cycle_q;
`endif
  end

  // Sequence advances on every capture, dropped or not, so gaps reveal losses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      seq_q  <= '0;
      lost_q <= 1'b0;
      drop_q <= '0;
    end else if (capture) begin
      seq_q <= seq_q + 1'b1;
      if (push_ok) begin
        lost_q <= 1'b0;
      end else begin
        lost_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  rv32i_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_REC_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (capture),
    .wdata (TRACE_REC_W'(rec)),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  assign trace_valid_o = ~fifo_empty;
  assign trace_rec_o   = trace_rec_t'(head);
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_rv32i_trace_tx.sv
// Directed scoreboard bench for rv32i_trace_tx: stimulus queues expected records,
// an independent monitor pops and compares each accepted record.
module tb_rv32i_trace_tx;
  import rv32i_trace_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              trace_en;
  logic              wb_valid;
  logic [31:0]       wb_pc;
  logic [31:0]       wb_instr;
  logic              regwrite;
  logic [4:0]        rd_addr;
  logic [31:0]       rd_data;
  logic              trace_valid;
  logic              trace_ready;
  trace_rec_t        trace_rec;
  logic [15:0]       drop_cnt;
  logic [3:0]        fifo_level;

  int tests = 0;
  int fails = 0;
  trace_rec_t exp_q[$];
  logic [31:0] ts_q[$];

  rv32i_trace_tx #(.DEPTH(8), .SEQ_W(16), .DROP_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .trace_en_i     (trace_en),
    .wb_valid_i     (wb_valid),
    .wb_pc_i        (wb_pc),
    .wb_instr_i     (wb_instr),
    .memwb_regwrite (regwrite),
    .memwb_rd_addr  (rd_addr),
    .memwb_rd_data  (rd_data),
    .trace_valid_o  (trace_valid),
    .trace_ready_i  (trace_ready),
    .trace_rec_o    (trace_rec),
    .drop_cnt_o     (drop_cnt),
    .fifo_level_o   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic trace_rec_t norm(input trace_rec_t r);
    trace_rec_t t;
    t = r;
`ifdef RV32I_TRACE_TIMESTAMP_EN
    t.tstamp = '0;
`endif
    return t;
  endfunction

  function automatic trace_rec_t mk(input logic [15:0] seq, input logic lost,
                                    input logic [31:0] pc, input logic [31:0] instr,
                                    input logic [4:0] rd, input logic [31:0] data);
    trace_rec_t t;
    t         = '0;
    t.seq     = seq;
    t.lost    = lost;
    t.pc      = pc;
    t.instr   = instr;
    t.rd      = rd;
    t.rd_data = data;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                        input logic rw, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = instr;
    regwrite = rw;
    rd_addr  = rd;
    rd_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  // Monitor: a record is consumed at the next rising edge when valid & ready here.
  initial begin
    trace_rec_t e;
    forever begin
      @(negedge clk);
      if (rst_n && trace_valid && trace_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got %h expected none", trace_rec);
        end else begin
          e = exp_q.pop_front();
          if (norm(trace_rec) !== e) begin
            fails++;
            $display("FAIL sb_record: got %h expected %h", norm(trace_rec), e);
          end
        end
`ifdef RV32I_TRACE_TIMESTAMP_EN
        ts_q.push_back(trace_rec.tstamp);
`endif
      end
    end
  end

  initial begin
    trace_rec_t hold_exp;
    rst_n       = 1'b0;
    trace_en    = 1'b1;
    wb_valid    = 1'b0;
    wb_pc       = '0;
    wb_instr    = '0;
    regwrite    = 1'b0;
    rd_addr     = '0;
    rd_data     = '0;
    trace_ready = 1'b0;

    // Test 1: reset state, then one retirement with ready high.
    tick();
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_rec_zero", 64'(trace_rec == '0), 64'd1);
    #2 rst_n = 1'b1;
    tick();
    trace_ready = 1'b1;
    exp_q.push_back(mk(16'd0, 1'b0, 32'h100, 32'h0050_0093, 5'd1, 32'd5));
    retire(32'h100, 32'h0050_0093, 1'b1, 5'd1, 32'd5);
    chk("t1_valid_after_edge", 64'(trace_valid), 64'd1);
    chk("t1_level", 64'(fifo_level), 64'd1);
    tick(); tick();
    chk("t1_drained", 64'(fifo_level), 64'd0);

    // Test 2: overflow with ready low; fresh reset so seq starts at 0.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    trace_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 8)
        exp_q.push_back(mk(16'(i), 1'b0, 32'h200 + 32'(4 * i), 32'h0000_0013,
                           5'(i + 1), 32'(16 * i + 1)));
      retire(32'h200 + 32'(4 * i), 32'h0000_0013, 1'b1, 5'(i + 1), 32'(16 * i + 1));
    end
    chk("t2_level_full", 64'(fifo_level), 64'd8);
    chk("t2_drop2", 64'(drop_cnt), 64'd2);

    // Test 3: full FIFO, push and pop together: no drop, lost flag carried.
    exp_q.push_back(mk(16'd10, 1'b1, 32'h228, 32'h0000_0013, 5'd11, 32'd161));
    trace_ready = 1'b1;
    retire(32'h228, 32'h0000_0013, 1'b1, 5'd11, 32'd161);
    chk("t3_level_kept", 64'(fifo_level), 64'd8);
    chk("t3_no_new_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 10; i++) tick();
    chk("t3_drained", 64'(fifo_level), 64'd0);

    // Test 4: store and x0 write both report zero data; store reports rd=0.
    exp_q.push_back(mk(16'd11, 1'b0, 32'h300, 32'h0031_2023, 5'd0, 32'd0));
    retire(32'h300, 32'h0031_2023, 1'b0, 5'd3, 32'hDEAD_BEEF);
    exp_q.push_back(mk(16'd12, 1'b0, 32'h304, 32'h0070_0013, 5'd0, 32'd0));
    retire(32'h304, 32'h0070_0013, 1'b1, 5'd0, 32'd7);
    tick(); tick(); tick();

    // Test 5: head record held stable under backpressure, then async reset mid-cycle.
    trace_ready = 1'b0;
    hold_exp = mk(16'd13, 1'b0, 32'h400, 32'h0010_0113, 5'd2, 32'h0000_0042);
    retire(32'h400, 32'h0010_0113, 1'b1, 5'd2, 32'h0000_0042);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (!(trace_valid && norm(trace_rec) == hold_exp)) begin
        fails++;
        $display("FAIL t5_hold_stable: got v=%0b %h expected v=1 %h",
                 trace_valid, norm(trace_rec), hold_exp);
      end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(trace_valid), 64'd0);
    chk("t5_rst_drop", 64'(drop_cnt), 64'd0);
    chk("t5_rst_level", 64'(fifo_level), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    trace_ready = 1'b1;
    exp_q.push_back(mk(16'd0, 1'b0, 32'h500, 32'h0000_0013, 5'd0, 32'd0));
    retire(32'h500, 32'h0000_0013, 1'b1, 5'd0, 32'd0);
    tick(); tick();

    // Test 6: disabled retirements are not captured and do not advance seq.
    ts_q.delete();
    exp_q.push_back(mk(16'd1, 1'b0, 32'h600, 32'h0010_0093, 5'd1, 32'd1));
    retire(32'h600, 32'h0010_0093, 1'b1, 5'd1, 32'd1);
    trace_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      retire(32'h604 + 32'(4 * i), 32'h0010_0093, 1'b1, 5'd1, 32'd9);
      chk("t6_no_capture", 64'(fifo_level), 64'd0);
    end
    trace_en = 1'b1;
    exp_q.push_back(mk(16'd2, 1'b0, 32'h610, 32'h0020_0093, 5'd1, 32'd2));
    retire(32'h610, 32'h0020_0093, 1'b1, 5'd1, 32'd2);
    tick(); tick();
    chk("t6_drained", 64'(fifo_level), 64'd0);
`ifdef RV32I_TRACE_TIMESTAMP_EN
    chk("t6_ts_count", 64'(ts_q.size()), 64'd2);
    if (ts_q.size() == 2)
      chk("t6_ts_delta", 64'(ts_q[1] - ts_q[0]), 64'd4);
`endif

    chk("sb_all_consumed", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
